// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM encoding, adder opcodes and width helper for the divider/ALU slice
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: multi-cycle unsigned divider driving an external WIDTH+1 adder/subtractor.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor skips the iterations and flags div_by_zero.
module nonrestoring_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH:0]   add_a,
    output logic [WIDTH:0]   add_b,
    output logic             add_op,
    input  logic [WIDTH:0]   add_result
);

    localparam int CW = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;

    state_t          r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_trap;

`ifdef DIV_ZERO_TRAP_EN
    logic r_dz;

    assign w_trap      = (divisor == '0);
    assign div_by_zero = r_dz;

    // Remember whether the accepted operation was a trapped divide-by-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dz <= 1'b0;
        else if (r_state == IDLE && in_valid)
            r_dz <= w_trap;
    end
`else
    assign w_trap      = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_q;
    assign remainder = r_r[WIDTH-1:0];

    // Control FSM plus quotient/partial-remainder datapath, one add/sub per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_in_ready <= 1'b0;
                    r_d        <= divisor;
                    r_count    <= CW'(WIDTH - 1);
                    if (w_trap) begin
                        r_q         <= '1;
                        r_r         <= {1'b0, dividend};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_q     <= dividend;
                        r_r     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_r <= add_result;
                    r_q <= {r_q[WIDTH-2:0], ~add_result[WIDTH]};
                    if (r_count == '0)
                        r_state <= FIX;
                    else
                        r_count <= r_count - 1'b1;
                end
                FIX: begin
                    if (r_r[WIDTH])
                        r_r <= add_result;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Adder operands: shifted remainder step in RUN, negative-remainder correction in FIX
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_op = OP_ADD;
        if (r_state == RUN) begin
            add_a  = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
            add_b  = {1'b0, r_d};
            add_op = r_r[WIDTH] ? OP_ADD : OP_SUB;
        end else if (r_state == FIX) begin
            add_a  = r_r;
            add_b  = {1'b0, r_d};
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb_nonrestoring_divider: randomized and directed checks against an arithmetic reference model
module tb_nonrestoring_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [W:0]   add_a;
    logic [W:0]   add_b;
    logic         add_op;
    logic [W:0]   add_result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External adder/subtractor
    assign add_result = add_op ? add_a + add_b : add_a - add_b;

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_result(add_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit poke);
        logic [W-1:0] eq, er;
        int           elat, lat;
        eq   = (b == 0) ? {W{1'b1}} : a / b;
        er   = (b == 0) ? a : a % b;
        elat = W + 2;
`ifdef DIV_ZERO_TRAP_EN
        if (b == 0) elat = 1;
`endif
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (poke && lat == 5) begin
                check("in_ready_busy", {63'd0, in_ready}, 64'd0);
                in_valid = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end else in_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("quotient", {32'd0, quotient}, {32'd0, eq});
        check("remainder", {32'd0, remainder}, {32'd0, er});
`ifdef DIV_ZERO_TRAP_EN
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, b == 0});
`else
        check("div_by_zero", {63'd0, div_by_zero}, 64'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready}, 64'd0);
            check("hold_q", {32'd0, quotient}, {32'd0, eq});
            check("hold_r", {32'd0, remainder}, {32'd0, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid", {63'd0, out_valid}, 64'd0);
        check("handoff_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] a, b;
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_q", {32'd0, quotient}, 64'd0);
        check("rst_r", {32'd0, remainder}, 64'd0);
        check("rst_dz", {63'd0, div_by_zero}, 64'd0);
        check("rst_add", {add_a, add_b, add_op}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op(32'd5, 32'd9, 0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        run_op(32'd123, 32'd0, 0, 1'b0);
        run_op(32'd1000, 32'd33, 5, 1'b0);
        run_op(32'hDEAD_BEEF, 32'd17, 0, 1'b1);

        // Reset in the middle of RUN
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_q", {32'd0, quotient}, 64'd0);
        check("mid_rst_add", {add_a, add_b, add_op}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        check("no_spurious", {63'd0, out_valid}, 64'd0);
        run_op(32'd100, 32'd7, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            b = $urandom;
            case (k % 4)
                0: b = b >> $urandom_range(31, 16);
                1: b = b >> $urandom_range(8, 0);
                2: a = a >> $urandom_range(20, 0);
                default: ;
            endcase
            if (k == 11) b = 0;
            run_op(a, b, $urandom_range(2, 0), k[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
